// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared source encodings and defaults for the CDB arbiter
package cdb_arbiter_pkg;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LB  = 1'b1
    } cdb_src_e;

    localparam int ROB_WIDTH = 4;
    localparam int ID_WIDTH  = 32;
    localparam int CDB_DEPTH = 2;

endpackage

// File: rtl/cdb_fifo.sv
// rtl/cdb_fifo.sv - small per-producer result FIFO with clear, registered count and head
module cdb_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 36
) (
    input  logic                     clk,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [$clog2(DEPTH):0]   count,
    output logic [W-1:0]             head
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    assign head = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by natural overflow
    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!clear && push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin arbiter sharing one registered CDB between ALU and load buffer
// Optional stats counters enabled by defining CDB_ARB_STATS_EN.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int ROB_W  = ROB_WIDTH,
    parameter int DATA_W = ID_WIDTH,
    parameter int DEPTH  = CDB_DEPTH
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              rob_cdb_rst_in,
    input  logic [ROB_W-1:0]  alu_cdb_b_in,
    input  logic [DATA_W-1:0] alu_cdb_result_in,
    output logic              cdb_alu_rdy_out,
    input  logic [ROB_W-1:0]  lbuffer_cdb_b_in,
    input  logic [DATA_W-1:0] lbuffer_cdb_result_in,
    output logic              cdb_lbuffer_rdy_out,
    output logic [ROB_W-1:0]  cdb_b_out,
    output logic [DATA_W-1:0] cdb_result_out,
`ifdef CDB_ARB_STATS_EN
    output logic [31:0]       stat_alu_grants_out,
    output logic [31:0]       stat_lb_grants_out,
    output logic [31:0]       stat_conflict_out,
`endif
    output logic              cdb_src_out
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = ROB_W + DATA_W;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [CW-1:0] alu_count;
    logic [CW-1:0] lb_count;
    logic [EW-1:0] alu_head;
    logic [EW-1:0] lb_head;
    logic [EW-1:0] win;
    cdb_src_e      rr_ptr;

    logic active;
    logic fifo_clear;
    logic alu_ne;
    logic lb_ne;
    logic grant_any;
    logic grant_lb;
    logic alu_push;
    logic lb_push;
    logic alu_pop;
    logic lb_pop;

    assign cdb_alu_rdy_out     = alu_count < FULL;
    assign cdb_lbuffer_rdy_out = lb_count < FULL;

    assign active     = rdy_in & ~rob_cdb_rst_in;
    assign fifo_clear = rst_in | (rdy_in & rob_cdb_rst_in);

    assign alu_push = active & (alu_cdb_b_in != '0) & cdb_alu_rdy_out;
    assign lb_push  = active & (lbuffer_cdb_b_in != '0) & cdb_lbuffer_rdy_out;

    // rr_ptr names the source preferred when both FIFOs hold entries
    assign alu_ne    = alu_count != '0;
    assign lb_ne     = lb_count != '0;
    assign grant_any = alu_ne | lb_ne;
    assign grant_lb  = lb_ne & (~alu_ne | (rr_ptr == SRC_LB));
    assign alu_pop   = active & alu_ne & ~grant_lb;
    assign lb_pop    = active & grant_lb;
    assign win       = grant_lb ? lb_head : alu_head;

    cdb_fifo #(.DEPTH(DEPTH), .W(EW)) u_alu_fifo (
        .clk   (clk_in),
        .clear (fifo_clear),
        .push  (alu_push),
        .pop   (alu_pop),
        .din   ({alu_cdb_b_in, alu_cdb_result_in}),
        .count (alu_count),
        .head  (alu_head)
    );

    cdb_fifo #(.DEPTH(DEPTH), .W(EW)) u_lb_fifo (
        .clk   (clk_in),
        .clear (fifo_clear),
        .push  (lb_push),
        .pop   (lb_pop),
        .din   ({lbuffer_cdb_b_in, lbuffer_cdb_result_in}),
        .count (lb_count),
        .head  (lb_head)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cdb_b_out      <= '0;
            cdb_result_out <= '0;
            cdb_src_out    <= SRC_ALU;
            rr_ptr         <= SRC_ALU;
        end else if (!rdy_in) begin
            cdb_b_out <= '0;
        end else if (rob_cdb_rst_in) begin
            cdb_b_out <= '0;
            rr_ptr    <= SRC_ALU;
        end else if (grant_any) begin
            cdb_b_out      <= win[EW-1:DATA_W];
            cdb_result_out <= win[DATA_W-1:0];
            cdb_src_out    <= grant_lb;
            rr_ptr         <= grant_lb ? SRC_ALU : SRC_LB;
        end else begin
            cdb_b_out <= '0;
        end
    end

`ifdef CDB_ARB_STATS_EN
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            stat_alu_grants_out <= '0;
            stat_lb_grants_out  <= '0;
            stat_conflict_out   <= '0;
        end else if (active) begin
            if (alu_pop && stat_alu_grants_out != 32'hFFFF_FFFF) begin
                stat_alu_grants_out <= stat_alu_grants_out + 32'd1;
            end
            if (lb_pop && stat_lb_grants_out != 32'hFFFF_FFFF) begin
                stat_lb_grants_out <= stat_lb_grants_out + 32'd1;
            end
            if (alu_ne && lb_ne && stat_conflict_out != 32'hFFFF_FFFF) begin
                stat_conflict_out <= stat_conflict_out + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed self-checking bench for cdb_arbiter
module tb_cdb_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        rob_cdb_rst_in;
    logic [3:0]  alu_cdb_b_in;
    logic [31:0] alu_cdb_result_in;
    logic        cdb_alu_rdy_out;
    logic [3:0]  lbuffer_cdb_b_in;
    logic [31:0] lbuffer_cdb_result_in;
    logic        cdb_lbuffer_rdy_out;
    logic [3:0]  cdb_b_out;
    logic [31:0] cdb_result_out;
    logic        cdb_src_out;
`ifdef CDB_ARB_STATS_EN
    logic [31:0] stat_alu_grants_out;
    logic [31:0] stat_lb_grants_out;
    logic [31:0] stat_conflict_out;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk_in = ~clk_in;

    cdb_arbiter dut (
        .clk_in                (clk_in),
        .rst_in                (rst_in),
        .rdy_in                (rdy_in),
        .rob_cdb_rst_in        (rob_cdb_rst_in),
        .alu_cdb_b_in          (alu_cdb_b_in),
        .alu_cdb_result_in     (alu_cdb_result_in),
        .cdb_alu_rdy_out       (cdb_alu_rdy_out),
        .lbuffer_cdb_b_in      (lbuffer_cdb_b_in),
        .lbuffer_cdb_result_in (lbuffer_cdb_result_in),
        .cdb_lbuffer_rdy_out   (cdb_lbuffer_rdy_out),
        .cdb_b_out             (cdb_b_out),
        .cdb_result_out        (cdb_result_out),
`ifdef CDB_ARB_STATS_EN
        .stat_alu_grants_out   (stat_alu_grants_out),
        .stat_lb_grants_out    (stat_lb_grants_out),
        .stat_conflict_out     (stat_conflict_out),
`endif
        .cdb_src_out           (cdb_src_out)
    );

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic clear_inputs();
        alu_cdb_b_in          = '0;
        alu_cdb_result_in     = '0;
        lbuffer_cdb_b_in      = '0;
        lbuffer_cdb_result_in = '0;
        rob_cdb_rst_in        = 1'b0;
        rdy_in                = 1'b1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_in = 1'b1;
        step();
        step();
        rst_in = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        alu_cdb_b_in = 4'd6;
        alu_cdb_result_in = 32'hDEAD;
        step();
        clear_inputs();
        step();
        total++;
        if (cdb_b_out !== 4'd6) begin
            bad++;
            $display("FAIL reset_pre_b: got %0d want 6", cdb_b_out);
        end
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        total++;
        if (cdb_b_out !== 4'd0 || cdb_result_out !== 32'd0 || cdb_src_out !== 1'b0 ||
            cdb_alu_rdy_out !== 1'b1 || cdb_lbuffer_rdy_out !== 1'b1) begin
            bad++;
            $display("FAIL reset_state: b=%0d res=%h src=%b ardy=%b lrdy=%b want 0 0 0 1 1",
                     cdb_b_out, cdb_result_out, cdb_src_out, cdb_alu_rdy_out, cdb_lbuffer_rdy_out);
        end
    endtask

    task automatic test_alu_only();
        do_reset();
        alu_cdb_b_in = 4'd3;
        alu_cdb_result_in = 32'h11;
        step();
        clear_inputs();
        total++;
        if (cdb_b_out !== 4'd0) begin
            bad++;
            $display("FAIL alu_only_c2: b=%0d want 0", cdb_b_out);
        end
        step();
        total++;
        if (cdb_b_out !== 4'd3 || cdb_result_out !== 32'h11 || cdb_src_out !== 1'b0) begin
            bad++;
            $display("FAIL alu_only_c3: b=%0d res=%h src=%b want 3 11 0", cdb_b_out, cdb_result_out, cdb_src_out);
        end
        step();
        total++;
        if (cdb_b_out !== 4'd0 || cdb_result_out !== 32'h11) begin
            bad++;
            $display("FAIL alu_only_c4: b=%0d res=%h want 0 11", cdb_b_out, cdb_result_out);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        alu_cdb_b_in = 4'd2;
        alu_cdb_result_in = 32'h22;
        lbuffer_cdb_b_in = 4'd5;
        lbuffer_cdb_result_in = 32'h55;
        step();
        clear_inputs();
        step();
        total++;
        if (cdb_b_out !== 4'd2 || cdb_src_out !== 1'b0 || cdb_result_out !== 32'h22) begin
            bad++;
            $display("FAIL simul_first: b=%0d src=%b res=%h want 2 0 22", cdb_b_out, cdb_src_out, cdb_result_out);
        end
        step();
        total++;
        if (cdb_b_out !== 4'd5 || cdb_src_out !== 1'b1 || cdb_result_out !== 32'h55) begin
            bad++;
            $display("FAIL simul_second: b=%0d src=%b res=%h want 5 1 55", cdb_b_out, cdb_src_out, cdb_result_out);
        end
        step();
        total++;
        if (cdb_b_out !== 4'd0) begin
            bad++;
            $display("FAIL simul_idle: b=%0d want 0", cdb_b_out);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i < 3) begin
                total++;
                if (cdb_alu_rdy_out !== 1'b1) begin
                    bad++;
                    $display("FAIL bp_rdy_%0d: rdy=%b want 1", i, cdb_alu_rdy_out);
                end
                alu_cdb_b_in = 4'(i + 1);
                alu_cdb_result_in = 32'h100 + i;
            end else begin
                alu_cdb_b_in = '0;
            end
            step();
            total++;
            if (i >= 1 && i <= 3) begin
                if (cdb_b_out !== 4'(i) || cdb_result_out !== 32'h100 + i - 1) begin
                    bad++;
                    $display("FAIL bp_bcast_%0d: b=%0d res=%h want %0d %h", i, cdb_b_out, cdb_result_out, i, 32'h100 + i - 1);
                end
            end else if (cdb_b_out !== 4'd0) begin
                bad++;
                $display("FAIL bp_idle_%0d: b=%0d want 0", i, cdb_b_out);
            end
        end
        clear_inputs();
    endtask

    task automatic test_contention();
        int aq[$];
        int lq[$];
        int pushes = 0;
        int seen = 0;
        int want;
        bit saw_low = 0;
        do_reset();
        for (int cyc = 0; cyc < 28; cyc++) begin
            if (cyc < 8) begin
                if (!cdb_alu_rdy_out || !cdb_lbuffer_rdy_out) saw_low = 1;
                if (cdb_alu_rdy_out) begin
                    alu_cdb_b_in = 4'(cyc + 1);
                    alu_cdb_result_in = 32'hA00 + cyc;
                    aq.push_back(cyc);
                    pushes++;
                end else alu_cdb_b_in = '0;
                if (cdb_lbuffer_rdy_out) begin
                    lbuffer_cdb_b_in = 4'(cyc + 1);
                    lbuffer_cdb_result_in = 32'hB00 + cyc;
                    lq.push_back(cyc);
                    pushes++;
                end else lbuffer_cdb_b_in = '0;
            end else begin
                alu_cdb_b_in = '0;
                lbuffer_cdb_b_in = '0;
            end
            step();
            if (cdb_b_out != 4'd0) begin
                total++;
                if (seen < 8 && cdb_src_out !== 1'(seen % 2)) begin
                    bad++;
                    $display("FAIL cont_alt_%0d: src=%b want %0d", seen, cdb_src_out, seen % 2);
                end
                total++;
                if ((cdb_src_out ? lq.size() : aq.size()) == 0) begin
                    bad++;
                    $display("FAIL cont_extra: b=%0d src=%b with nothing pending", cdb_b_out, cdb_src_out);
                end else begin
                    want = cdb_src_out ? lq.pop_front() : aq.pop_front();
                    if (cdb_b_out !== 4'(want + 1) ||
                        cdb_result_out !== (cdb_src_out ? 32'hB00 : 32'hA00) + want) begin
                        bad++;
                        $display("FAIL cont_order: b=%0d res=%h want tag %0d", cdb_b_out, cdb_result_out, want + 1);
                    end
                end
                seen++;
            end
        end
        clear_inputs();
        total++;
        if (seen != pushes || aq.size() != 0 || lq.size() != 0 || !saw_low) begin
            bad++;
            $display("FAIL cont_totals: seen=%0d pushes=%0d left=%0d/%0d rdy_low=%0d want equal, 0/0, 1",
                     seen, pushes, aq.size(), lq.size(), saw_low);
        end
    endtask

    task automatic test_flush();
        do_reset();
        alu_cdb_b_in = 4'd1; alu_cdb_result_in = 32'hA1;
        lbuffer_cdb_b_in = 4'd2; lbuffer_cdb_result_in = 32'hB2;
        step();
        lbuffer_cdb_b_in = '0;
        alu_cdb_b_in = 4'd3; alu_cdb_result_in = 32'hA3;
        step();
        total++;
        if (cdb_b_out !== 4'd1 || cdb_src_out !== 1'b0 || cdb_lbuffer_rdy_out !== 1'b1) begin
            bad++;
            $display("FAIL flush_pre: b=%0d src=%b lrdy=%b want 1 0 1", cdb_b_out, cdb_src_out, cdb_lbuffer_rdy_out);
        end
        alu_cdb_b_in = '0;
        lbuffer_cdb_b_in = 4'd7; lbuffer_cdb_result_in = 32'h77;
        rob_cdb_rst_in = 1'b1;
        step();
        clear_inputs();
        total++;
        if (cdb_b_out !== 4'd0 || cdb_alu_rdy_out !== 1'b1 || cdb_lbuffer_rdy_out !== 1'b1) begin
            bad++;
            $display("FAIL flush_after: b=%0d ardy=%b lrdy=%b want 0 1 1", cdb_b_out, cdb_alu_rdy_out, cdb_lbuffer_rdy_out);
        end
        alu_cdb_b_in = 4'd4; alu_cdb_result_in = 32'hA4;
        lbuffer_cdb_b_in = 4'd5; lbuffer_cdb_result_in = 32'hB5;
        step();
        clear_inputs();
        total++;
        if (cdb_b_out !== 4'd0) begin
            bad++;
            $display("FAIL flush_empty: b=%0d want 0", cdb_b_out);
        end
        step();
        total++;
        if (cdb_b_out !== 4'd4 || cdb_src_out !== 1'b0) begin
            bad++;
            $display("FAIL flush_rr_alu: b=%0d src=%b want 4 0", cdb_b_out, cdb_src_out);
        end
        step();
        total++;
        if (cdb_b_out !== 4'd5 || cdb_src_out !== 1'b1) begin
            bad++;
            $display("FAIL flush_rr_lb: b=%0d src=%b want 5 1", cdb_b_out, cdb_src_out);
        end
        step();
        total++;
        if (cdb_b_out !== 4'd0) begin
            bad++;
            $display("FAIL flush_drained: b=%0d want 0", cdb_b_out);
        end
    endtask

    task automatic test_stall();
        do_reset();
        alu_cdb_b_in = 4'd1; alu_cdb_result_in = 32'hC1;
        lbuffer_cdb_b_in = 4'd2; lbuffer_cdb_result_in = 32'hC2;
        step();
        clear_inputs();
        rdy_in = 1'b0;
        alu_cdb_b_in = 4'd9; alu_cdb_result_in = 32'hC9;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (cdb_b_out !== 4'd0) begin
                bad++;
                $display("FAIL stall_b_%0d: b=%0d want 0", i, cdb_b_out);
            end
        end
`ifdef CDB_ARB_STATS_EN
        total++;
        if (stat_alu_grants_out !== 32'd0 || stat_lb_grants_out !== 32'd0 || stat_conflict_out !== 32'd0) begin
            bad++;
            $display("FAIL stall_stats: %0d %0d %0d want 0 0 0", stat_alu_grants_out, stat_lb_grants_out, stat_conflict_out);
        end
`endif
        clear_inputs();
        step();
        total++;
        if (cdb_b_out !== 4'd1 || cdb_src_out !== 1'b0 || cdb_result_out !== 32'hC1) begin
            bad++;
            $display("FAIL stall_resume1: b=%0d src=%b res=%h want 1 0 c1", cdb_b_out, cdb_src_out, cdb_result_out);
        end
        step();
        total++;
        if (cdb_b_out !== 4'd2 || cdb_src_out !== 1'b1 || cdb_result_out !== 32'hC2) begin
            bad++;
            $display("FAIL stall_resume2: b=%0d src=%b res=%h want 2 1 c2", cdb_b_out, cdb_src_out, cdb_result_out);
        end
        step();
        total++;
        if (cdb_b_out !== 4'd0) begin
            bad++;
            $display("FAIL stall_no_ignored: b=%0d want 0", cdb_b_out);
        end
`ifdef CDB_ARB_STATS_EN
        total++;
        if (stat_alu_grants_out !== 32'd1 || stat_lb_grants_out !== 32'd1 || stat_conflict_out !== 32'd1) begin
            bad++;
            $display("FAIL stats_after: %0d %0d %0d want 1 1 1", stat_alu_grants_out, stat_lb_grants_out, stat_conflict_out);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        rst_in = 1'b1;
        clear_inputs();
        test_reset();
        test_alu_only();
        test_simultaneous();
        test_backpressure();
        test_contention();
        test_flush();
        test_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
